countdown_sequencer: RTL and testbench

//   Sequences the countdown datapath. Latches the 3-bit timer selection, drives the

---
 rtl/countdown_pkg.sv | 15 +
 rtl/hold_counter.sv | 35 +++
 rtl/countdown_sequencer.sv | 137 +++++++++++++
 tb/tb_countdown_sequencer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and widths for the countdown sequencer and its hold counter.
package countdown_pkg;

    localparam int unsigned TIMER_W = 3;
    localparam int unsigned HOLD_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter with enable and zero flag; stops at zero instead of wrapping.
module hold_counter
    import countdown_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              en,
    output logic              zero
);

    logic [HOLD_W-1:0] count_q;
    logic [HOLD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown control FSM: timer latch, load pulse, gated decrements, timed done.
// Optional AUTO_RELOAD_EN: RUN at zero reloads the same timer instead of entering DONE.
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int unsigned PLS_CYCLES = 2,
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               cancel,
    input  logic [TIMER_W-1:0] sel,
    input  logic               tick,
    input  logic               cnt_zero,
    output logic [TIMER_W-1:0] timer,
    output logic               pls,
    output logic               cnt_en,
    output logic               busy,
    output logic               done
);

    // Counter is loaded with N-1 so the zero flag marks the last cycle/tick of the hold.
    localparam logic [HOLD_W-1:0] PLS_HOLD  = HOLD_W'(PLS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DONE_HOLD = HOLD_W'(DONE_TICKS - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               pls_q, pls_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               hold_load;
    logic [HOLD_W-1:0]  hold_val;
    logic               hold_en;
    logic               hold_zero;
`ifdef AUTO_RELOAD_EN
    logic               reload_pulse;
`endif

    hold_counter u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (hold_val),
        .en       (hold_en),
        .zero     (hold_zero)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
`ifdef AUTO_RELOAD_EN
        reload_pulse = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!cancel && start) begin
                    timer_d = sel;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cancel)         state_d = ST_IDLE;
                else if (hold_zero) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
`ifdef AUTO_RELOAD_EN
                    state_d      = ST_LOAD;
                    reload_pulse = 1'b1;
`else
                    state_d = ST_DONE;
`endif
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (cancel)      state_d = ST_IDLE;
                else if (!pause) state_d = ST_RUN;
            end
            ST_DONE: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    timer_d = sel;
                    state_d = ST_LOAD;
                end else if (tick && hold_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pls_d  = (state_d == ST_LOAD);
        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_PAUSE);
`ifdef AUTO_RELOAD_EN
        done_d = reload_pulse;
`else
        done_d = (state_d == ST_DONE);
`endif

        // Reload on every state entry; only LOAD and DONE carry a non-zero hold.
        hold_load = (state_d != state_q);
        if (state_d == ST_LOAD)      hold_val = PLS_HOLD;
        else if (state_d == ST_DONE) hold_val = DONE_HOLD;
        else                         hold_val = '0;
        hold_en = (state_q == ST_LOAD) || ((state_q == ST_DONE) && tick);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pls_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pls_q   <= pls_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cnt_en = tick && (state_q == ST_RUN) && !cnt_zero;
    assign timer  = timer_q;
    assign pls    = pls_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer: directed scenarios plus random stimulus
// against a behavioural model. Build with AUTO_RELOAD_EN to exercise the reload variant.
module tb_countdown_sequencer;

    localparam int PLS = 2;
    localparam int DT  = 3;

    logic       clk = 1'b0;
    logic       rst, start, pause, cancel, tick, cnt_zero;
    logic [2:0] sel;
    logic [2:0] timer;
    logic       pls, cnt_en, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    countdown_sequencer #(.PLS_CYCLES(PLS), .DONE_TICKS(DT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .cancel   (cancel),
        .sel      (sel),
        .tick     (tick),
        .cnt_zero (cnt_zero),
        .timer    (timer),
        .pls      (pls),
        .cnt_en   (cnt_en),
        .busy     (busy),
        .done     (done)
    );

    // Behavioural model: phase of operation plus elapsed-count bookkeeping.
    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_e;
    mode_e      m_mode;
    logic [2:0] m_timer;
    int         m_load_cycles;
    int         m_ticks;
    bit         m_pulse;

    function automatic bit exp_cnt_en();
        return tick && (m_mode == M_RUN) && !cnt_zero;
    endfunction
    function automatic bit exp_pls();
        return m_mode == M_LOAD;
    endfunction
    function automatic bit exp_busy();
        return (m_mode == M_LOAD) || (m_mode == M_RUN) || (m_mode == M_PAUSE);
    endfunction
    function automatic bit exp_done();
`ifdef AUTO_RELOAD_EN
        return m_pulse;
`else
        return m_mode == M_DONE;
`endif
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_timer = 3'd0; m_load_cycles = 0; m_ticks = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        m_pulse = 0;
        if (m_mode != M_IDLE && cancel) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (start && !cancel) begin
                    m_timer = sel; m_mode = M_LOAD; m_load_cycles = 0;
                end
                M_LOAD: begin
                    m_load_cycles++;
                    if (m_load_cycles == PLS) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (cnt_zero) begin
`ifdef AUTO_RELOAD_EN
                        m_mode = M_LOAD; m_load_cycles = 0; m_pulse = 1;
`else
                        m_mode = M_DONE; m_ticks = 0;
`endif
                    end else if (pause) begin
                        m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (!pause) m_mode = M_RUN;
                M_DONE: begin
                    if (start) begin
                        m_timer = sel; m_mode = M_LOAD; m_load_cycles = 0;
                    end else if (tick) begin
                        m_ticks++;
                        if (m_ticks == DT) m_mode = M_IDLE;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; pause = 0; cancel = 0; tick = 0; cnt_zero = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        sel = 3'd0;
        rst = 1;
        #1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic go_run(input logic [2:0] s);
        sel = s; start = 1;
        clk_edge();
        start = 0;
        clk_edge();
        clk_edge();
    endtask

    task automatic test_reset();
        do_reset();
        go_run(3'd6);
        tick = 1;
        #2 rst = 1;
        #1;
        n_tests++;
        if (timer !== 3'd0 || pls !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: timer=%0d pls=%b busy=%b done=%b cnt_en=%b, required all 0",
                     timer, pls, busy, done, cnt_en);
        end
        @(posedge clk);
        #1 rst = 0;
        tick = 0;
        model_reset();
    endtask

    task automatic test_load();
        do_reset();
        sel = 3'd5; start = 1;
        clk_edge();
        start = 0; sel = 3'd2;
        n_tests++;
        if (timer !== 3'd5 || pls !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_first: timer=%0d pls=%b busy=%b, required 5 1 1", timer, pls, busy);
        end
        clk_edge();
        n_tests++;
        if (pls !== 1'b1 || timer !== 3'd5) begin
            n_fail++;
            $display("FAIL load_second: pls=%b timer=%0d, required 1 5", pls, timer);
        end
        clk_edge();
        n_tests++;
        if (pls !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_end: pls=%b busy=%b done=%b, required 0 1 0", pls, busy, done);
        end
        tick = 1;
        @(negedge clk);
        n_tests++;
        if (cnt_en !== 1'b1) begin
            n_fail++;
            $display("FAIL load_run_tick: cnt_en=%b, required 1", cnt_en);
        end
        clk_edge();
        tick = 0;
    endtask

`ifndef AUTO_RELOAD_EN
    task automatic test_run_done();
        int pulses;
        do_reset();
        go_run(3'($urandom_range(1, 7)));
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick = 1;
            @(negedge clk);
            if (cnt_en === 1'b1) pulses++;
            clk_edge();
            tick = 0;
            clk_edge();
        end
        n_tests++;
        if (pulses !== 4) begin
            n_fail++;
            $display("FAIL run_pulses: got %0d cnt_en pulses, required 4", pulses);
        end
        tick = 1; cnt_zero = 1;
        @(negedge clk);
        n_tests++;
        if (cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL run_zero_tick: cnt_en=%b, required 0", cnt_en);
        end
        clk_edge();
        tick = 0;
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || pls !== 1'b0) begin
            n_fail++;
            $display("FAIL run_to_done: done=%b busy=%b pls=%b, required 1 0 0", done, busy, pls);
        end
    endtask

    task automatic test_done_hold();
        for (int i = 1; i <= DT; i++) begin
            clk_edge();
            n_tests++;
            if (done !== 1'b1) begin
                n_fail++;
                $display("FAIL done_gap_%0d: done=%b, required 1", i, done);
            end
            tick = 1;
            @(negedge clk);
            n_tests++;
            if (done !== 1'b1) begin
                n_fail++;
                $display("FAIL done_tick_%0d: done=%b, required 1", i, done);
            end
            clk_edge();
            tick = 0;
        end
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_exit: done=%b busy=%b, required 0 0", done, busy);
        end
        cnt_zero = 0;
    endtask
`endif

    task automatic test_pause();
        do_reset();
        go_run(3'd3);
        pause = 1;
        clk_edge();
        for (int i = 0; i < 3; i++) begin
            tick = 1;
            @(negedge clk);
            n_tests++;
            if (cnt_en !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL pause_tick_%0d: cnt_en=%b busy=%b, required 0 1", i, cnt_en, busy);
            end
            clk_edge();
            tick = 0;
            clk_edge();
        end
        pause = 0;
        clk_edge();
        tick = 1;
        @(negedge clk);
        n_tests++;
        if (cnt_en !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_resume: cnt_en=%b, required 1", cnt_en);
        end
        clk_edge();
        tick = 0;
    endtask

    task automatic test_cancel();
        do_reset();
        sel = 3'd6; start = 1;
        clk_edge();
        start = 0; cancel = 1;
        clk_edge();
        cancel = 0;
        n_tests++;
        if (pls !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || timer !== 3'd6) begin
            n_fail++;
            $display("FAIL cancel_load: pls=%b busy=%b done=%b timer=%0d, required 0 0 0 6",
                     pls, busy, done, timer);
        end
        clk_edge();
        clk_edge();
        n_tests++;
        if (pls !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_stays: pls=%b busy=%b, required 0 0", pls, busy);
        end
        sel = 3'd1; start = 1; cancel = 1;
        clk_edge();
        start = 0; cancel = 0;
        n_tests++;
        if (pls !== 1'b0 || busy !== 1'b0 || timer !== 3'd6) begin
            n_fail++;
            $display("FAIL start_cancel_idle: pls=%b busy=%b timer=%0d, required 0 0 6", pls, busy, timer);
        end
        clk_edge();
        n_tests++;
        if (pls !== 1'b0) begin
            n_fail++;
            $display("FAIL start_cancel_noload: pls=%b, required 0", pls);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        sel = 3'd7; start = 1;
        clk_edge();
        start = 0;
        #2 rst = 1;
        #1;
        n_tests++;
        if (pls !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || timer !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_load: pls=%b busy=%b done=%b timer=%0d, required 0 0 0 0",
                     pls, busy, done, timer);
        end
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload();
        do_reset();
        go_run(3'd4);
        tick = 1; cnt_zero = 1;
        @(negedge clk);
        n_tests++;
        if (cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_zero_tick: cnt_en=%b, required 0", cnt_en);
        end
        clk_edge();
        tick = 0; cnt_zero = 0;
        n_tests++;
        if (done !== 1'b1 || pls !== 1'b1 || timer !== 3'd4 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_reload: done=%b pls=%b timer=%0d busy=%b, required 1 1 4 1",
                     done, pls, timer, busy);
        end
        clk_edge();
        n_tests++;
        if (done !== 1'b0 || pls !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_pulse_width: done=%b pls=%b, required 0 1", done, pls);
        end
        clk_edge();
        n_tests++;
        if (pls !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_rerun: pls=%b busy=%b, required 0 1", pls, busy);
        end
        cnt_zero = 1;
        clk_edge();
        cnt_zero = 0;
        #2 rst = 1;
        #1;
        n_tests++;
        if (pls !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || timer !== 3'd0 || cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_reset_mid_pls: pls=%b done=%b busy=%b timer=%0d cnt_en=%b, required all 0",
                     pls, done, busy, timer, cnt_en);
        end
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            pause    = ($urandom_range(0, 7) == 0);
            cancel   = ($urandom_range(0, 19) == 0);
            tick     = ($urandom_range(0, 2) == 0);
            cnt_zero = ($urandom_range(0, 7) == 0);
            sel      = 3'($urandom_range(0, 7));
            @(negedge clk);
            n_tests++;
            if (cnt_en !== exp_cnt_en()) begin
                n_fail++;
                $display("FAIL rand_cnt_en[%0d]: got %b, required %b", i, cnt_en, exp_cnt_en());
            end
            clk_edge();
            n_tests++;
            if (timer !== m_timer || pls !== exp_pls() || busy !== exp_busy() || done !== exp_done()) begin
                n_fail++;
                $display("FAIL rand_regs[%0d]: timer=%0d pls=%b busy=%b done=%b, required %0d %b %b %b",
                         i, timer, pls, busy, done, m_timer, exp_pls(), exp_busy(), exp_done());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        sel = 3'd0;
        rst = 0;
        model_reset();
        test_reset();
        test_load();
`ifndef AUTO_RELOAD_EN
        test_run_done();
        test_done_hold();
`endif
        test_pause();
        test_cancel();
        test_reset_mid_load();
`ifdef AUTO_RELOAD_EN
        test_auto_reload();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
